// File: rtl/led_switch_round_scorer_pkg.sv
// led_switch_pkg: shared types and helpers for the LED/switch round scorer.
//   - round_state_e : FSM state encoding (IDLE / ARMED / RESULT)
//   - sat_inc       : saturating increment on a 32-bit carrier
//   - DEF_*         : default parameter values for the scorer
// Optional feature macro used elsewhere in this slice: LED_SWITCH_MISS_PENALTY_EN.
package led_switch_pkg;

    localparam int DEF_N_CH          = 18;
    localparam int DEF_SCORE_W       = 8;
    localparam int DEF_STREAK_W      = 4;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_TIMEOUT       = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RESULT = 2'd2
    } round_state_e;

    // Returns v+1, but never exceeds max_v. Callers truncate back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/led_switch_round_scorer_if.sv
// led_switch_round_scorer_if: bundle between pattern generator / switch bank
// (master) and the round scorer (slave).
//   leds, leds_valid : target pattern and start-of-round strobe (master -> slave)
//   switches         : synchronised switch bank (master -> slave)
//   busy, hit, miss  : round status and result strobes (slave -> master)
//   score, streak    : running totals (slave -> master)
// Handshake: leds_valid is a one-cycle strobe with no ready; it is accepted only
// while busy is low and leds is non-zero, otherwise it is silently dropped.
interface led_switch_round_scorer_if #(
    parameter int N_CH     = 18,
    parameter int SCORE_W  = 8,
    parameter int STREAK_W = 4
) ();
    logic [N_CH-1:0]     leds;
    logic                leds_valid;
    logic [N_CH-1:0]     switches;
    logic                busy;
    logic                hit;
    logic                miss;
    logic [SCORE_W-1:0]  score;
    logic [STREAK_W-1:0] streak;

    modport master (
        output leds, leds_valid, switches,
        input  busy, hit, miss, score, streak
    );

    modport slave (
        input  leds, leds_valid, switches,
        output busy, hit, miss, score, streak
    );
endinterface

// File: rtl/led_switch_round_scorer_match.sv
// switch_match_filter: holds the captured target pattern and counts consecutive
// cycles in which the switch bank equals it exactly.
//   clk, reset   : clock, synchronous active-high reset
//   load, leds   : capture leds as the new target and clear the stable count
//   armed        : count only while the round is running
//   switches     : synchronised switch bank
//   match_stable : combinational pulse, high in the cycle whose matching sample
//                  completes STABLE_CYCLES consecutive matches
module switch_match_filter
    import led_switch_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [N_CH-1:0] leds,
    input  logic            armed,
    input  logic [N_CH-1:0] switches,
    output logic            match_stable
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    logic [N_CH-1:0] target_q, target_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic            is_match;

    // Exact compare: an extra switch outside the target also breaks the match.
    assign is_match     = (switches == target_q);
    assign match_stable = armed && is_match && (stable_q == SW'(STABLE_CYCLES - 1));

    always_comb begin
        target_d = target_q;
        stable_d = stable_q;
        if (load) begin
            target_d = leds;
            stable_d = '0;
        end else if (armed) begin
            if (!is_match)
                stable_d = '0;
            else if (stable_q != SW'(STABLE_CYCLES))
                stable_d = stable_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
            stable_q <= '0;
        end else begin
            target_q <= target_d;
            stable_q <= stable_d;
        end
    end
endmodule

// File: rtl/led_switch_round_scorer.sv
// led_switch_round_scorer: round FSM, timeout counter and score/streak registers
// for the LED/switch reaction game.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of led_switch_round_scorer_if (leds/leds_valid/switches
//                in; busy/hit/miss/score/streak out, all registered)
//   dbg_state  : current FSM state
// Macro LED_SWITCH_MISS_PENALTY_EN: when defined a miss also decrements score
// (saturating at 0); when undefined a miss leaves score unchanged.
module led_switch_round_scorer
    import led_switch_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int SCORE_W       = DEF_SCORE_W,
    parameter int STREAK_W      = DEF_STREAK_W,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    led_switch_round_scorer_if.slave  bus,
    output round_state_e              dbg_state
);
    localparam int EW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] SCORE_MAX  = 32'((64'd1 << SCORE_W) - 64'd1);
    localparam logic [31:0] STREAK_MAX = 32'((64'd1 << STREAK_W) - 64'd1);

    round_state_e        state_q, state_d;
    logic [EW-1:0]       elapsed_q, elapsed_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic                busy_q, busy_d;

    logic start;
    logic armed;
    logic match_stable;
    logic timeout_now;

    assign start = (state_q == ST_IDLE) && bus.leds_valid && (bus.leds != '0);
    assign armed = (state_q == ST_ARMED);
    // The ARMED cycle being evaluated is the TIMEOUT-th one.
    assign timeout_now = armed && (elapsed_q == EW'(TIMEOUT - 1));

    switch_match_filter #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_match (
        .clk          (clk),
        .reset        (reset),
        .load         (start),
        .leds         (bus.leds),
        .armed        (armed),
        .switches     (bus.switches),
        .match_stable (match_stable)
    );

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        score_d   = score_q;
        streak_d  = streak_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ARMED;
                    elapsed_d = '0;
                end
            end
            ST_ARMED: begin
                elapsed_d = elapsed_q + EW'(1);
                // Hit is checked first so it wins over a simultaneous timeout.
                if (match_stable) begin
                    state_d  = ST_RESULT;
                    hit_d    = 1'b1;
                    score_d  = SCORE_W'(sat_inc(32'(score_q), SCORE_MAX));
                    streak_d = STREAK_W'(sat_inc(32'(streak_q), STREAK_MAX));
                end else if (timeout_now) begin
                    state_d  = ST_RESULT;
                    miss_d   = 1'b1;
                    streak_d = '0;
`ifdef LED_SWITCH_MISS_PENALTY_EN
                    score_d  = (score_q == '0) ? '0 : score_q - SCORE_W'(1);
`else
                    score_d  = score_q;
`endif
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            elapsed_q <= '0;
            score_q   <= '0;
            streak_q  <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            score_q   <= score_d;
            streak_q  <= streak_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.hit    = hit_q;
    assign bus.miss   = miss_q;
    assign bus.score  = score_q;
    assign bus.streak = streak_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_led_switch_round_scorer.sv
// tb_led_switch_round_scorer: directed + randomised bench for led_switch_round_scorer
// with SCORE_W=3, STREAK_W=4, STABLE_CYCLES=4, TIMEOUT=20. The reference model
// decides each round's outcome from the per-cycle switch sequence (run-length of
// exact matches vs. elapsed budget) and tracks score/streak with integer min/max.
module tb_led_switch_round_scorer;
    import led_switch_pkg::*;

    localparam int N   = 18;
    localparam int SW  = 3;
    localparam int STW = 4;
    localparam int S   = 4;
    localparam int TO  = 20;

    logic clk;
    logic reset;
    round_state_e dbg_state;

    led_switch_round_scorer_if #(.N_CH(N), .SCORE_W(SW), .STREAK_W(STW)) bus ();

    led_switch_round_scorer #(
        .N_CH(N), .SCORE_W(SW), .STREAK_W(STW), .STABLE_CYCLES(S), .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m_score  = 0;
    int m_streak = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag, input logic b, input logic h, input logic m);
        check({tag, "_busy"}, 32'(bus.busy), 32'(b));
        check({tag, "_hit"},  32'(bus.hit),  32'(h));
        check({tag, "_miss"}, 32'(bus.miss), 32'(m));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_score  = 0;
        m_streak = 0;
    endtask

    // mode 0: always match, 1: random (3/4 match), 2: never match,
    // 3: match 3, mismatch 1, then match
    task automatic play_round(input logic [N-1:0] tgt, input int mode, input bit inject, input string tag);
        logic [N-1:0] seq [TO];
        logic [N-1:0] one;
        int  run;
        int  k_end;
        bit  exp_hit;
        one = 1;
        for (int k = 0; k < TO; k++) begin
            case (mode)
                0: seq[k] = tgt;
                1: seq[k] = ($urandom_range(0, 3) != 0) ? tgt : tgt ^ (one << $urandom_range(0, N - 1));
                2: seq[k] = tgt ^ (one << $urandom_range(0, N - 1));
                default: seq[k] = (k == 3) ? tgt ^ (one << $urandom_range(0, N - 1)) : tgt;
            endcase
        end
        // Outcome model: first index where the match run reaches S, else the budget end.
        run     = 0;
        exp_hit = 1'b0;
        k_end   = TO - 1;
        for (int k = 0; k < TO; k++) begin
            run = (seq[k] == tgt) ? run + 1 : 0;
            if (run == S) begin
                exp_hit = 1'b1;
                k_end   = k;
                break;
            end
        end
        if (exp_hit) begin
            m_score  = (m_score + 1 > 7) ? 7 : m_score + 1;
            m_streak = (m_streak + 1 > 15) ? 15 : m_streak + 1;
        end else begin
            m_streak = 0;
`ifdef LED_SWITCH_MISS_PENALTY_EN
            m_score = (m_score > 0) ? m_score - 1 : 0;
`endif
        end

        @(posedge clk); #1;
        bus.leds       = tgt;
        bus.leds_valid = 1'b1;
        @(posedge clk); #1;
        bus.leds_valid = 1'b0;
        for (int c = 0; c <= k_end + 2; c++) begin
            bus.switches = (c <= k_end) ? seq[c] : N'($urandom);
            if (inject && c == 1) begin
                bus.leds       = ~tgt;
                bus.leds_valid = 1'b1;
            end
            @(negedge clk);
            if (c <= k_end) begin
                check_outputs({tag, "_armed"}, 1'b1, 1'b0, 1'b0);
            end else if (c == k_end + 1) begin
                check_outputs({tag, "_result"}, 1'b1, exp_hit, !exp_hit);
                check({tag, "_score"},  32'(bus.score),  32'(m_score));
                check({tag, "_streak"}, 32'(bus.streak), 32'(m_streak));
            end else begin
                check_outputs({tag, "_after"}, 1'b0, 1'b0, 1'b0);
                check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
            end
            @(posedge clk); #1;
            bus.leds_valid = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] tgt;
        reset          = 1'b0;
        bus.leds       = '0;
        bus.leds_valid = 1'b0;
        bus.switches   = '0;
        do_reset();

        // reset state
        @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0);
        check("reset_score",  32'(bus.score),  0);
        check("reset_streak", 32'(bus.streak), 0);
        check("reset_state",  32'(dbg_state),  32'(ST_IDLE));

        // leds_valid with zero pattern is ignored
        @(posedge clk); #1;
        bus.leds       = '0;
        bus.leds_valid = 1'b1;
        @(posedge clk); #1;
        bus.leds_valid = 1'b0;
        @(negedge clk);
        check_outputs("zero_leds", 1'b0, 1'b0, 1'b0);
        check("zero_leds_state", 32'(dbg_state), 32'(ST_IDLE));

        // directed rounds
        play_round(18'h00005, 0, 1'b0, "basic_hit");
        play_round(18'h0A0F1, 3, 1'b0, "glitch");
        play_round(18'h20001, 0, 1'b1, "inject");
        play_round(18'h00030, 2, 1'b0, "timeout_a");
        play_round(18'h00030, 2, 1'b0, "timeout_b");
        play_round(18'h00030, 2, 1'b0, "timeout_c");
        play_round(18'h00030, 2, 1'b0, "timeout_d");

        // saturation: 16 straight hits
        for (int i = 0; i < 16; i++) begin
            tgt = N'($urandom);
            if (tgt == '0) tgt = 18'h1;
            play_round(tgt, 0, 1'b0, "saturate");
        end

        // randomised rounds
        for (int i = 0; i < 12; i++) begin
            tgt = N'($urandom);
            if (tgt == '0) tgt = 18'h2;
            play_round(tgt, 1, ($urandom_range(0, 1) == 1), "random");
        end

        // reset mid-ARMED aborts the round without strobes
        @(posedge clk); #1;
        bus.leds       = 18'h00777;
        bus.leds_valid = 1'b1;
        @(posedge clk); #1;
        bus.leds_valid = 1'b0;
        bus.switches   = 18'h00777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        m_score  = 0;
        m_streak = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_outputs("mid_reset", 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        check("mid_reset_state",  32'(dbg_state),  32'(ST_IDLE));
        check("mid_reset_score",  32'(bus.score),  0);
        check("mid_reset_streak", 32'(bus.streak), 0);
        play_round(18'h00777, 0, 1'b0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/led_switch_round_scorer.md
# led_switch_round_scorer

Parametrised round-based scorer for the LED/switch reaction game. The pattern generator presents a target LED pattern, and the player must set the switch bank to exactly that pattern. The pattern must hold stable for a configurable number of cycles before a timeout expires. The block sits between the pattern generator and the score display, and produces score, streak and per-round hit/miss strobes.

## Interface
- N_CH, 18: number of LED/switch channels
- SCORE_W, 8: score counter width
- STREAK_W, 4: streak counter width
- STABLE_CYCLES, 4: consecutive matching cycles required for a hit (≥1)
- TIMEOUT, 50_000_000: maximum ARMED cycles before a miss (> STABLE_CYCLES)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- leds  in  N_CH  target pattern, sampled only with leds_valid
- leds_valid  in  1  single-cycle strobe: start a round
- switches  in  N_CH  switch bank, already synchronised to clk
- busy  out  1  high in ARMED and RESULT
- hit  out  1  one-cycle strobe: round won
- miss  out  1  one-cycle strobe: round timed out
- score  out  SCORE_W  running score
- streak  out  STREAK_W  consecutive hits

## Operation
- States: IDLE, ARMED, RESULT.
- IDLE:
  - On leds_valid with leds != 0: capture target = leds, clear the elapsed and stable counters, and go to ARMED.
  - leds_valid with leds == 0 is ignored.
- ARMED, each cycle:
  - elapsed += 1.
  - If switches == target, stable += 1; otherwise stable = 0.
  - The match is exact over all N_CH bits. A switch set outside the target breaks the match.
- Hit: stable reaches STABLE_CYCLES. Go to RESULT with hit=1.
- Miss: elapsed reaches TIMEOUT without a hit. Go to RESULT with miss=1.
- Hit and timeout on the same cycle: the hit wins and miss stays 0.
- RESULT lasts exactly one cycle, then the FSM returns to IDLE.
- leds_valid during ARMED or RESULT is ignored. There is no restart and no queuing.
- On hit:
  - score += 1, saturating at 2^SCORE_W−1.
  - streak += 1, saturating at 2^STREAK_W−1.
- On miss: streak = 0. The score change is set by the configuration macro below.
- Reset mid-round aborts the round. No hit or miss strobe is produced.

## Timing
- Reset values: state IDLE; busy=0, hit=0, miss=0, score=0, streak=0; counters and target cleared.
- Edge T captures leds_valid, so busy=1 from cycle T+1.
- With switches matching from cycle T+1 onward, hit is high in cycle T+STABLE_CYCLES+1.
- score and streak update on the same edge that raises hit or miss.
- busy falls one cycle after the strobe, and the next leds_valid is accepted in that cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- LED_SWITCH_MISS_PENALTY_EN:
  - Defined: a miss decrements score by 1, saturating at 0.
  - Undefined: a miss leaves score unchanged.
- In both cases a miss clears streak.

## Structure
- Package led_switch_pkg holds:
  - the state enum (IDLE/ARMED/RESULT);
  - a saturating-increment helper function;
  - default width constants.
- Sub-module switch_match_filter holds:
  - the target register and the stable counter;
  - an output match_stable pulse.
- The top level holds the FSM, the timeout counter and the score/streak registers.

## Test plan
- Basic hit:
  - Stimulus: reset, then leds=18'h00005 with leds_valid; switches=18'h00005 from the next cycle.
  - Response: hit 5 cycles after the strobe edge (STABLE_CYCLES=4); score=1, streak=1; busy low one cycle later.
- Glitch:
  - Stimulus: the switches match for 3 cycles, mismatch for 1 cycle, then match.
  - Response: hit comes 4 cycles after the re-match; exactly one hit.
- Timeout with TIMEOUT=20 and switches never matching:
  - miss in the 20th ARMED cycle; streak cleared.
  - Macro defined with score=3: score becomes 2. Macro defined with score=0: score stays 0.
  - Macro undefined: score unchanged.
- Saturation with SCORE_W=3 and 9 consecutive hits:
  - score saturates at 7.
  - streak saturates at 15 after 15 hits (STREAK_W=4).
- Ignored strobes:
  - leds_valid during ARMED does not change the target.
  - leds_valid with leds=0 in IDLE leaves busy=0.
- Reset mid-ARMED: state returns to IDLE; no hit or miss strobe; score=0.
